// File: rtl/ascon_msg_packer.sv
// ============================================================================
// ascon_msg_packer: packs a byte stream into padded 64-bit Ascon-Hash blocks.
// Optional macro ASCON_PACK_LE_EN: little-endian lanes with 0x01 pad byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ascon_msg_packer #(
   parameter int BW = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          msg_start,
   input  logic [7:0]    msg_len,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          start,
   output logic [7:0]    m_length,
   output logic          blk_valid,
   output logic [BW-1:0] blk_data,
   output logic          blk_last,
   input  logic          blk_ready,
   output logic          busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_EMIT = 2'd2;
   localparam logic [1:0] S_PAD  = 2'd3;

`ifdef ASCON_PACK_LE_EN
   localparam logic [7:0]    C_PAD     = 8'h01;
   localparam logic [BW-1:0] C_PAD_BLK = {{(BW-8){1'b0}}, C_PAD};
`else
   localparam logic [7:0]    C_PAD     = 8'h80;
   localparam logic [BW-1:0] C_PAD_BLK = {C_PAD, {(BW-8){1'b0}}};
`endif

   // Bit position of the least-significant bit of byte lane k.
   function automatic logic [5:0] lane_lsb(input logic [2:0] k);
`ifdef ASCON_PACK_LE_EN
      return {k, 3'b000};
`else
      return 6'd56 - {k, 3'b000};
`endif
   endfunction

   logic [1:0]    state_q, state_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [BW-1:0] blk_q, blk_d;
   logic          last_q, last_d;
   logic          start_q, start_d;

   logic [2:0]    w_lane;
   logic [2:0]    w_lane_nxt;
   logic [7:0]    w_cnt_inc;
   logic          w_final;

   assign w_lane     = cnt_q[2:0];
   assign w_lane_nxt = w_lane + 3'd1;
   assign w_cnt_inc  = cnt_q + 8'd1;
   assign w_final    = (w_cnt_inc == len_q);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q   <= 8'd0;
         cnt_q   <= 8'd0;
         blk_q   <= '0;
         last_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         last_q  <= last_d;
         start_q <= start_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;
      last_d  = last_q;
      start_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (msg_start) begin
               len_d   = msg_len;
               start_d = 1'b1;
               cnt_d   = 8'd0;
               last_d  = 1'b0;
               if (msg_len == 8'd0) begin
                  blk_d   = C_PAD_BLK;
                  state_d = S_PAD;
               end else begin
                  blk_d   = '0;
                  state_d = S_FILL;
               end
            end
         end
         S_FILL: begin
            if (in_valid) begin
               blk_d[lane_lsb(w_lane) +: 8] = in_data;
               cnt_d = w_cnt_inc;
               // A final byte short of lane 7 leaves room for the pad in this block.
               if (w_final && (w_lane != 3'd7)) begin
                  blk_d[lane_lsb(w_lane_nxt) +: 8] = C_PAD;
                  last_d = 1'b1;
               end
               if (w_final || (w_lane == 3'd7)) state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (blk_ready) begin
               if (cnt_q != len_q) begin
                  blk_d   = '0;
                  state_d = S_FILL;
               end else if (len_q[2:0] == 3'd0) begin
                  blk_d   = C_PAD_BLK;
                  state_d = S_PAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_PAD: begin
            if (blk_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_FILL);
      busy      = (state_q != S_IDLE);
      blk_valid = (state_q == S_EMIT) || (state_q == S_PAD);
      blk_last  = (state_q == S_PAD) || ((state_q == S_EMIT) && last_q);
      start     = start_q;
      m_length  = len_q;
      blk_data  = blk_q;
   end

endmodule

`default_nettype wire

// File: doc/ascon_msg_packer.md
ASCON_MSG_PACKER -- requirements
Module: ascon_msg_packer

Interface
REQ-001 The block SHALL have parameter BW, default 64, meaning output block width in bits (only 64 supported).
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, reset: one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port msg_start, input, 1, one-cycle request to begin a message, honoured only in IDLE.
REQ-005 The block SHALL have port msg_len, input, 8, message length in bytes (0..255), sampled with msg_start.
REQ-006 The block SHALL have port in_valid, input, 1, byte-stream valid.
REQ-007 The block SHALL have port in_data, input, 8, message byte.
REQ-008 The block SHALL have port in_ready, output, 1, byte accepted when in_valid and in_ready are both high.
REQ-009 The block SHALL have port start, output, 1, one-cycle pulse to the hash datapath at message begin.
REQ-010 The block SHALL have port m_length, output, 8, registered copy of msg_len, held until the next accepted msg_start.
REQ-011 The block SHALL have port blk_valid, output, 1, padded block available.
REQ-012 The block SHALL have port blk_data, output, BW, padded message block (new_block to the datapath).
REQ-013 The block SHALL have port blk_last, output, 1, qualifies the final block of the message.
REQ-014 The block SHALL have port blk_ready, input, 1, block consumed when blk_valid and blk_ready are both high.
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, EMIT and PAD.
REQ-017 In IDLE, msg_start SHALL latch msg_len into m_length, pulse start on the next cycle, and clear the byte and lane counters.
REQ-018 From IDLE, msg_start with msg_len=0 SHALL go to PAD; any other msg_len SHALL go to FILL.
REQ-019 In FILL, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-020 In FILL, each accepted byte SHALL be written into lane k (0..7), where k is the byte index modulo 8.
REQ-021 On lane 7 or on the message's final byte, the block register SHALL be loaded including padding, and the next state SHALL be EMIT, with blk_valid high from the following cycle.
REQ-022 Padding: the lane after the final byte SHALL hold the pad byte and all higher lanes SHALL be 0; a full block SHALL receive no pad.
REQ-023 In EMIT, blk_valid SHALL be 1 and blk_data SHALL be held stable until handshake.
REQ-024 On the EMIT handshake with bytes remaining, the next state SHALL be FILL.
REQ-025 On the EMIT handshake with the message complete and msg_len%8==0 (non-zero), the next state SHALL be PAD.
REQ-026 On the EMIT handshake with the message complete otherwise, the next state SHALL be IDLE.
REQ-027 blk_last SHALL be 1 only on the final block: the block carrying the pad byte.
REQ-028 In PAD, blk_data SHALL be the pad byte in lane 0 with all other lanes 0, blk_valid and blk_last SHALL be 1, and the handshake SHALL go to IDLE.
REQ-029 msg_start outside IDLE SHALL be ignored; in_valid outside FILL SHALL be ignored, and no byte is lost.
REQ-030 Blocks per message SHALL equal floor(msg_len/8)+1, always.
REQ-031 The byte counter SHALL be 8 bits with no wrap, since msg_len is at most 255.
REQ-032 Throughput: one byte per cycle in FILL; the minimum EMIT dwell SHALL be 1 cycle.

Reset
REQ-033 On rst at a clk edge: state=IDLE, counters=0, and start, blk_valid, blk_last and busy SHALL be 0.
REQ-034 On rst, blk_data and m_length SHALL be 0, and in_ready SHALL be 0.
REQ-035 Reset mid-message SHALL discard the partial block with no further output; the next msg_start SHALL behave as from power-up.

Configuration
REQ-036 Macro ASCON_PACK_LE_EN: when defined, lane k SHALL occupy bits [8k+7:8k] (little-endian) and the pad byte SHALL be 0x01 (SP 800-232 style).
REQ-037 Without ASCON_PACK_LE_EN, lane k SHALL occupy bits [63-8k:56-8k] (big-endian) and the pad byte SHALL be 0x80 (Ascon v1.2 style).

Verification (macro undefined unless stated)
REQ-038 msg_len=0, blk_ready=1 -> start pulse, one block 0x8000000000000000 with blk_last=1, back to IDLE.
REQ-039 msg_len=3, bytes 0xAA,0xBB,0xCC -> single block 0xAABBCC8000000000, blk_last=1.
REQ-040 msg_len=8, bytes 0x00..0x07 -> block 0x0001020304050607 with blk_last=0, then 0x8000000000000000 with blk_last=1.
REQ-041 msg_len=10, blk_ready held low 5 cycles on the first block -> in_ready=0 and blk_data stable throughout the stall; second block 0x0809800000000000.
REQ-042 rst asserted after 5 of 20 bytes, then msg_len=1, byte 0x5A -> only block 0x5A80000000000000 emitted; msg_start during busy has no effect.
REQ-043 ASCON_PACK_LE_EN defined, msg_len=3, bytes 0xAA,0xBB,0xCC -> block 0x0000000001CCBBAA.
